// File: rtl/bresenham_pkg.sv
// Shared definitions for the raster generators: FSM state encoding and a
// width helper for sizing signed error/delta arithmetic.
package bresenham_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_INIT = 2'd2,
      S_DRAW = 2'd3
   } state_t;

   function automatic int unsigned max_width(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/bresenham_step.sv
// One Bresenham iteration: error update and conditional minor-axis step.
module bresenham_step
   import bresenham_pkg::*;
#(
   parameter int unsigned P_ERR_W = 12
) (
   input  logic signed [P_ERR_W-1:0] i_err,
   input  logic signed [P_ERR_W-1:0] i_dm,
   input  logic signed [P_ERR_W-1:0] i_dmaj,
   input  logic signed [P_ERR_W-1:0] i_minor,
   input  logic signed [P_ERR_W-1:0] i_minor_step,
   output logic signed [P_ERR_W-1:0] o_err,
   output logic signed [P_ERR_W-1:0] o_minor
);

   logic signed [P_ERR_W-1:0] t;

   always_comb begin
      t       = i_err - i_dm;
      o_err   = t;
      o_minor = i_minor;
      if (t < 0) begin
         o_err   = t + i_dmaj;
         o_minor = i_minor + i_minor_step;
      end
   end

endmodule

// File: rtl/bresenham_stream.sv
// Line rasteriser: accepts a line command and streams every pixel from
// (x0,y0) to (x1,y1) with a last flag, backpressure and abort.
module bresenham_stream
   import bresenham_pkg::*;
#(
   parameter int unsigned P_X_COORD_W   = 11,
   parameter int unsigned P_Y_COORD_W   = 11,
   parameter bit          P_INCLUDE_END = 1'b1
) (
   input  logic                   i_clk,
   input  logic                   i_reset_n,
   input  logic [P_X_COORD_W-1:0] i_x0,
   input  logic [P_Y_COORD_W-1:0] i_y0,
   input  logic [P_X_COORD_W-1:0] i_x1,
   input  logic [P_Y_COORD_W-1:0] i_y1,
   input  logic                   i_cmd_valid,
   output logic                   o_cmd_ready,
   input  logic                   i_abort,
   output logic [P_X_COORD_W-1:0] o_pt_x,
   output logic [P_Y_COORD_W-1:0] o_pt_y,
   output logic                   o_pt_valid,
   output logic                   o_pt_last,
   input  logic                   i_pt_ready,
   output logic                   o_busy,
   output logic                   o_done
);

   localparam int unsigned P_ERR_W = max_width(P_X_COORD_W, P_Y_COORD_W) + 1;

   typedef logic signed [P_ERR_W-1:0] err_t;

   state_t state, state_nxt;

   err_t x0_r, y0_r, x1_r, y1_r;
   err_t dmaj, dmin, maj_step, min_step;
   err_t maj, minor, err;
   logic steep;
   logic [P_ERR_W-1:0] count;
   logic done_r;

   err_t diff_x, diff_y, abs_x, abs_y;
   err_t err_nxt, minor_nxt;
   logic [P_ERR_W-1:0] init_count;
   logic calc_steep, cmd_fire, pt_fire, is_last, done_nxt;

   assign o_cmd_ready = (state == S_IDLE) && !done_r;
   assign o_busy      = (state != S_IDLE);
   assign o_pt_valid  = (state == S_DRAW);
   assign is_last     = (count == P_ERR_W'(1));
   assign o_pt_last   = o_pt_valid && is_last;
   assign o_done      = done_r;
   assign cmd_fire    = i_cmd_valid && o_cmd_ready;
   assign pt_fire     = o_pt_valid && i_pt_ready;

   // Major/minor registers are axis-agnostic; steep swaps them back to X/Y.
   assign o_pt_x = steep ? minor[P_X_COORD_W-1:0] : maj[P_X_COORD_W-1:0];
   assign o_pt_y = steep ? maj[P_Y_COORD_W-1:0]   : minor[P_Y_COORD_W-1:0];

   always_comb begin
      diff_x     = x1_r - x0_r;
      diff_y     = y1_r - y0_r;
      abs_x      = (diff_x < 0) ? -diff_x : diff_x;
      abs_y      = (diff_y < 0) ? -diff_y : diff_y;
      calc_steep = (abs_y > abs_x);
      init_count = $unsigned(dmaj) + {{(P_ERR_W-1){1'b0}}, P_INCLUDE_END};
   end

   bresenham_step #(.P_ERR_W(P_ERR_W)) u_step (
      .i_err        (err),
      .i_dm         (dmin),
      .i_dmaj       (dmaj),
      .i_minor      (minor),
      .i_minor_step (min_step),
      .o_err        (err_nxt),
      .o_minor      (minor_nxt)
   );

   always_comb begin
      state_nxt = state;
      done_nxt  = 1'b0;
      unique case (state)
         S_IDLE: if (cmd_fire) state_nxt = S_CALC;
         S_CALC: state_nxt = S_INIT;
         S_INIT: begin
            state_nxt = (init_count == '0) ? S_IDLE : S_DRAW;
            done_nxt  = (init_count == '0);
         end
         S_DRAW: begin
            if (pt_fire && is_last) begin
               state_nxt = S_IDLE;
               done_nxt  = 1'b1;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
      // Abort wins over any handshake or completion in the same cycle.
      if (i_abort && (state != S_IDLE)) begin
         state_nxt = S_IDLE;
         done_nxt  = 1'b0;
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_reset_n) state <= S_IDLE;
      else            state <= state_nxt;
   end

   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         x0_r     <= '0;
         y0_r     <= '0;
         x1_r     <= '0;
         y1_r     <= '0;
         dmaj     <= '0;
         dmin     <= '0;
         maj_step <= '0;
         min_step <= '0;
         maj      <= '0;
         minor    <= '0;
         err      <= '0;
         steep    <= 1'b0;
         count    <= '0;
         done_r   <= 1'b0;
      end else begin
         done_r <= done_nxt;
         if (cmd_fire) begin
            x0_r <= P_ERR_W'(i_x0);
            y0_r <= P_ERR_W'(i_y0);
            x1_r <= P_ERR_W'(i_x1);
            y1_r <= P_ERR_W'(i_y1);
         end
         if (!i_abort) begin
            unique case (state)
               S_CALC: begin
                  steep <= calc_steep;
                  if (calc_steep) begin
                     dmaj     <= abs_y;
                     dmin     <= abs_x;
                     maj_step <= (diff_y < 0) ? '1 : err_t'(1);
                     min_step <= (diff_x < 0) ? '1 : ((diff_x == 0) ? '0 : err_t'(1));
                  end else begin
                     dmaj     <= abs_x;
                     dmin     <= abs_y;
                     maj_step <= (diff_x < 0) ? '1 : err_t'(1);
                     min_step <= (diff_y < 0) ? '1 : ((diff_y == 0) ? '0 : err_t'(1));
                  end
               end
               S_INIT: begin
                  err   <= dmaj >>> 1;
                  maj   <= steep ? y0_r : x0_r;
                  minor <= steep ? x0_r : y0_r;
                  count <= init_count;
               end
               S_DRAW: begin
                  if (pt_fire) begin
                     maj   <= maj + maj_step;
                     err   <= err_nxt;
                     minor <= minor_nxt;
                     count <= count - P_ERR_W'(1);
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_bresenham_stream.sv
// Directed bench for bresenham_stream (endpoint included and excluded) and
// the bresenham_step iteration block.
`timescale 1ns/1ps
module tb_bresenham_stream;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [10:0] x0 = '0, y0 = '0, x1 = '0, y1 = '0;
   logic        cmd_valid_a = 1'b0, cmd_valid_b = 1'b0;
   logic        abort = 1'b0, pt_ready = 1'b1;

   logic        a_cmd_ready, a_valid, a_last, a_busy, a_done;
   logic [10:0] a_x, a_y;
   logic        b_cmd_ready, b_valid, b_last, b_busy, b_done;
   logic [10:0] b_x, b_y;

   logic signed [11:0] s_err, s_dm, s_dmaj, s_minor, s_step, s_err_o, s_minor_o;

   int n_checks = 0;
   int n_pass = 0;

   int qx[$], qy[$], ql[$];
   int exp_x[$], exp_y[$];
   int first_lat, done_cnt, done_cyc, last_at;
   bit timed_out;

   always #5 clk = ~clk;

   bresenham_stream #(.P_X_COORD_W(11), .P_Y_COORD_W(11), .P_INCLUDE_END(1'b1)) u_dut_a (
      .i_clk(clk), .i_reset_n(rst_n),
      .i_x0(x0), .i_y0(y0), .i_x1(x1), .i_y1(y1),
      .i_cmd_valid(cmd_valid_a), .o_cmd_ready(a_cmd_ready), .i_abort(abort),
      .o_pt_x(a_x), .o_pt_y(a_y), .o_pt_valid(a_valid), .o_pt_last(a_last),
      .i_pt_ready(pt_ready), .o_busy(a_busy), .o_done(a_done)
   );

   bresenham_stream #(.P_X_COORD_W(11), .P_Y_COORD_W(11), .P_INCLUDE_END(1'b0)) u_dut_b (
      .i_clk(clk), .i_reset_n(rst_n),
      .i_x0(x0), .i_y0(y0), .i_x1(x1), .i_y1(y1),
      .i_cmd_valid(cmd_valid_b), .o_cmd_ready(b_cmd_ready), .i_abort(abort),
      .o_pt_x(b_x), .o_pt_y(b_y), .o_pt_valid(b_valid), .o_pt_last(b_last),
      .i_pt_ready(pt_ready), .o_busy(b_busy), .o_done(b_done)
   );

   bresenham_step #(.P_ERR_W(12)) u_step (
      .i_err(s_err), .i_dm(s_dm), .i_dmaj(s_dmaj), .i_minor(s_minor),
      .i_minor_step(s_step), .o_err(s_err_o), .o_minor(s_minor_o)
   );

   // Issue one command with ready held high and record the output stream.
   task automatic run_line(input bit use_b, input int ax0, input int ay0,
                           input int ax1, input int ay1);
      bit v, l, d;
      qx.delete(); qy.delete(); ql.delete();
      first_lat = -1; done_cnt = 0; done_cyc = -1; last_at = -1;
      x0 = 11'(ax0); y0 = 11'(ay0); x1 = 11'(ax1); y1 = 11'(ay1);
      pt_ready = 1'b1;
      if (use_b) cmd_valid_b = 1'b1; else cmd_valid_a = 1'b1;
      @(posedge clk); #1;
      cmd_valid_a = 1'b0; cmd_valid_b = 1'b0;
      for (int cyc = 1; cyc < 2200; cyc++) begin
         v = use_b ? b_valid : a_valid;
         l = use_b ? b_last  : a_last;
         d = use_b ? b_done  : a_done;
         if (d) begin
            done_cnt++;
            if (done_cyc < 0) done_cyc = cyc;
         end
         if (v) begin
            if (first_lat < 0) first_lat = cyc;
            qx.push_back(int'(use_b ? b_x : a_x));
            qy.push_back(int'(use_b ? b_y : a_y));
            ql.push_back(int'(l));
            if (l) last_at = cyc;
         end
         if (done_cyc >= 0 && cyc >= done_cyc + 3) break;
         @(posedge clk); #1;
      end
      timed_out = (done_cyc < 0);
   endtask

   task automatic test_line(input string name, input bit use_b, input int ax0, input int ay0,
                            input int ax1, input int ay1);
      int bad;
      run_line(use_b, ax0, ay0, ax1, ay1);
      n_checks++;
      if (timed_out !== 1'b0) $display("FAIL %s_timeout: no o_done within cycle budget", name);
      else n_pass++;
      n_checks++;
      if (qx.size() !== exp_x.size())
         $display("FAIL %s_count: got %0d points, want %0d", name, qx.size(), exp_x.size());
      else n_pass++;
      if (qx.size() == exp_x.size()) begin
         bad = 0;
         for (int i = 0; i < exp_x.size(); i++) begin
            if (qx[i] !== exp_x[i] || qy[i] !== exp_y[i]) begin
               if (bad < 4)
                  $display("FAIL %s_pt%0d: got (%0d,%0d), want (%0d,%0d)",
                           name, i, qx[i], qy[i], exp_x[i], exp_y[i]);
               bad++;
            end
            if (ql[i] !== ((i == exp_x.size() - 1) ? 1 : 0)) begin
               if (bad < 4) $display("FAIL %s_last%0d: got %0d", name, i, ql[i]);
               bad++;
            end
         end
         n_checks++;
         if (bad !== 0) $display("FAIL %s_points: %0d bad, want 0", name, bad);
         else n_pass++;
      end
      n_checks++;
      if (done_cnt !== 1) $display("FAIL %s_done_count: got %0d, want 1", name, done_cnt);
      else n_pass++;
      if (exp_x.size() > 0) begin
         n_checks++;
         if (first_lat !== 3) $display("FAIL %s_latency: got %0d, want 3", name, first_lat);
         else n_pass++;
         n_checks++;
         if (done_cyc !== last_at + 1)
            $display("FAIL %s_done_timing: got cycle %0d, want %0d", name, done_cyc, last_at + 1);
         else n_pass++;
      end else begin
         n_checks++;
         if (done_cyc !== 3) $display("FAIL %s_done_timing: got cycle %0d, want 3", name, done_cyc);
         else n_pass++;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      @(posedge clk); #1;
      n_checks++;
      if ({a_valid, a_last, a_done, a_busy, a_cmd_ready} !== 5'b00001)
         $display("FAIL reset_ctrl: got %b, want 00001", {a_valid, a_last, a_done, a_busy, a_cmd_ready});
      else n_pass++;
      n_checks++;
      if (a_x !== 11'd0 || a_y !== 11'd0)
         $display("FAIL reset_xy: got (%0d,%0d), want (0,0)", a_x, a_y);
      else n_pass++;
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_step();
      s_err = 12'sd2; s_dm = 12'sd2; s_dmaj = 12'sd5; s_minor = 12'sd0; s_step = 12'sd1;
      #1;
      n_checks++;
      if (s_err_o !== 12'sd0 || s_minor_o !== 12'sd0)
         $display("FAIL step_nocarry: got err %0d minor %0d, want 0 0", s_err_o, s_minor_o);
      else n_pass++;
      s_err = 12'sd0;
      #1;
      n_checks++;
      if (s_err_o !== 12'sd3 || s_minor_o !== 12'sd1)
         $display("FAIL step_carry: got err %0d minor %0d, want 3 1", s_err_o, s_minor_o);
      else n_pass++;
      s_err = 12'sd1023; s_dm = 12'sd2047; s_dmaj = 12'sd2047; s_minor = 12'sd10; s_step = -12'sd1;
      #1;
      n_checks++;
      if (s_err_o !== 12'sd1023 || s_minor_o !== 12'sd9)
         $display("FAIL step_fullscale: got err %0d minor %0d, want 1023 9", s_err_o, s_minor_o);
      else n_pass++;
   endtask

   task automatic test_backpressure();
      int hold, cyc, lx, ly, bad;
      bit held;
      qx.delete(); qy.delete();
      hold = 0; held = 0; bad = 0; done_cyc = -1;
      x0 = 11'd0; y0 = 11'd0; x1 = 11'd5; y1 = 11'd2;
      pt_ready = 1'b1; cmd_valid_a = 1'b1;
      @(posedge clk); #1;
      cmd_valid_a = 1'b0;
      for (cyc = 1; cyc < 60; cyc++) begin
         if (a_done && done_cyc < 0) done_cyc = cyc;
         if (done_cyc >= 0) break;
         if (hold > 0) begin
            if (!a_valid || a_x !== 11'(lx) || a_y !== 11'(ly) || a_last !== 1'b0) bad++;
            hold--;
            if (hold == 0) pt_ready = 1'b1;
         end else if (a_valid) begin
            qx.push_back(int'(a_x)); qy.push_back(int'(a_y));
            if (!held && a_x == 11'd2 && a_y == 11'd1) begin
               held = 1; hold = 3; lx = 2; ly = 1; pt_ready = 1'b0;
            end
         end
         @(posedge clk); #1;
      end
      pt_ready = 1'b1;
      n_checks++;
      if (held !== 1'b1 || bad !== 0)
         $display("FAIL bp_hold: held %0d unstable %0d, want 1 0", held, bad);
      else n_pass++;
      n_checks++;
      if (qx.size() !== 6 || done_cyc < 0)
         $display("FAIL bp_count: got %0d points done %0d, want 6 points", qx.size(), done_cyc);
      else n_pass++;
      if (qx.size() == 6) begin
         bad = 0;
         for (int i = 0; i < 6; i++) if (qx[i] !== exp_x[i] || qy[i] !== exp_y[i]) bad++;
         n_checks++;
         if (bad !== 0) $display("FAIL bp_order: %0d wrong points, want 0", bad);
         else n_pass++;
      end
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic test_abort();
      int seen, dn;
      x0 = 11'd0; y0 = 11'd0; x1 = 11'd5; y1 = 11'd2;
      pt_ready = 1'b1; cmd_valid_a = 1'b1;
      @(posedge clk); #1;
      cmd_valid_a = 1'b0;
      seen = 0;
      for (int c = 0; c < 10 && seen < 2; c++) begin
         if (a_valid) seen++;
         if (seen < 2) begin @(posedge clk); #1; end
      end
      n_checks++;
      if (seen !== 2 || a_x !== 11'd1 || a_y !== 11'd0)
         $display("FAIL abort_second_pt: got (%0d,%0d) seen %0d, want (1,0) 2", a_x, a_y, seen);
      else n_pass++;
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      n_checks++;
      if ({a_valid, a_busy, a_cmd_ready, a_done} !== 4'b0010)
         $display("FAIL abort_state: got %b, want 0010", {a_valid, a_busy, a_cmd_ready, a_done});
      else n_pass++;
      dn = 0;
      repeat (4) begin @(posedge clk); #1; if (a_done || a_valid) dn++; end
      n_checks++;
      if (dn !== 0) $display("FAIL abort_quiet: got %0d active cycles, want 0", dn);
      else n_pass++;
   endtask

   task automatic test_midline_reset();
      int c;
      x0 = 11'd0; y0 = 11'd0; x1 = 11'd5; y1 = 11'd2;
      pt_ready = 1'b1; cmd_valid_a = 1'b1;
      @(posedge clk); #1;
      cmd_valid_a = 1'b0;
      for (c = 0; c < 10 && !a_valid; c++) begin @(posedge clk); #1; end
      @(posedge clk); #1;
      n_checks++;
      if (a_valid !== 1'b1 || a_x !== 11'd1) $display("FAIL rst_midline_pre: got valid %0d x %0d, want 1 1", a_valid, a_x);
      else n_pass++;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      n_checks++;
      if ({a_valid, a_last, a_done, a_busy, a_cmd_ready} !== 5'b00001 || a_x !== 11'd0 || a_y !== 11'd0)
         $display("FAIL rst_midline: got %b (%0d,%0d), want 00001 (0,0)",
                  {a_valid, a_last, a_done, a_busy, a_cmd_ready}, a_x, a_y);
      else n_pass++;
      c = 0;
      repeat (4) begin @(posedge clk); #1; if (a_done || a_valid) c++; end
      n_checks++;
      if (c !== 0) $display("FAIL rst_midline_quiet: got %0d active cycles, want 0", c);
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_step();

      exp_x = '{0, 1, 2, 3, 4, 5}; exp_y = '{0, 0, 1, 1, 2, 2};
      test_line("shallow", 1'b0, 0, 0, 5, 2);
      test_backpressure();

      exp_x = '{5, 4, 3, 2, 1, 0}; exp_y = '{2, 2, 1, 1, 0, 0};
      test_line("reverse", 1'b0, 5, 2, 0, 0);

      exp_x = '{2, 2, 1, 1, 0}; exp_y = '{0, 1, 2, 3, 4};
      test_line("steep", 1'b0, 2, 0, 0, 4);

      exp_x = '{7}; exp_y = '{7};
      test_line("degenerate", 1'b0, 7, 7, 7, 7);

      exp_x.delete(); exp_y.delete();
      test_line("noend_degenerate", 1'b1, 7, 7, 7, 7);

      exp_x = '{0, 1, 2, 3, 4}; exp_y = '{0, 0, 1, 1, 2};
      test_line("noend_shallow", 1'b1, 0, 0, 5, 2);

      test_abort();
      test_midline_reset();

      exp_x.delete(); exp_y.delete();
      for (int i = 0; i < 2048; i++) begin exp_x.push_back(i); exp_y.push_back(i); end
      test_line("fullscale", 1'b0, 0, 0, 2047, 2047);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
